// File: rtl/receiver_pkg.sv
// Shared types and constants for the 16x oversampling serial receiver.
// Frame: one low start bit, DATA_BITS data bits LSB first, one high stop bit.
package receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Typed copies so comparisons against the counters stay width-matched
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(MID_SAMPLE);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

endpackage

// File: rtl/receiver_sample_tick.sv
// Sample-tick divider: one-clk tick every BAUD_DIV clks, restarted by clear.
// The tick is combinational so the first tick lands exactly BAUD_DIV clks after clear drops.
module sample_tick #(
  parameter int BAUD_DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/receiver.sv
// Serial byte receiver with 16x oversampling and single mid-bit sampling.
// Delivers each correctly framed byte on rx_data with a one-clk rx_status pulse.
module receiver
  import receiver_pkg::*;
#(
  parameter int BAUD_DIV = 326
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_error,
  output logic       rx_busy
);

  rx_state_t state_q, state_d;

  logic din_meta_p0, din_sync_p1, din_prev_p2;
  logic fall_edge;

  logic              tick;
  logic              tick_clear;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic mid_start, bit_end;
  logic tick_restart, bit_restart, sample_bit, good_stop, bad_stop;

  // Stage 0/1: two-flop synchronizer, stage 2: previous value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_p0 <= 1'b1;
      din_sync_p1 <= 1'b1;
      din_prev_p2 <= 1'b1;
    end else begin
      din_meta_p0 <= din;
      din_sync_p1 <= din_meta_p0;
      din_prev_p2 <= din_sync_p1;
    end
  end

  assign fall_edge = din_prev_p2 && !din_sync_p1;

  // Divider held in reset throughout IDLE so a frame always starts from a clean phase
  assign tick_clear = (state_q == IDLE);

  sample_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_sample_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign mid_start = tick && (tick_cnt == MID_TICK);
  assign bit_end   = tick && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_restart = 1'b0;
    bit_restart  = 1'b0;
    sample_bit   = 1'b0;
    good_stop    = 1'b0;
    bad_stop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
        end
      end
      START: begin
        if (mid_start) begin
          if (din_sync_p1) begin
            state_d = IDLE;
          end else begin
            // Realign the tick counter so later samples fall 16 ticks apart at mid-bit
            state_d      = DATA;
            tick_restart = 1'b1;
            bit_restart  = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          sample_bit = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          good_stop = din_sync_p1;
          bad_stop  = !din_sync_p1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_clear || tick_restart) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (bit_restart) begin
      bit_cnt <= '0;
    end else if (sample_bit) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register is pure data: every bit is rewritten before it is ever used
  always_ff @(posedge clk) begin
    if (sample_bit) begin
      shift_reg[bit_cnt] <= din_sync_p1;
    end
  end

  // Stage 3: registered result and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_status <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_status <= good_stop;
      rx_error  <= bad_stop;
      if (good_stop) begin
        rx_data <= shift_reg;
      end
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Randomized bench for receiver: drives serial frames and compares every pulse
// against a frame-level model (byte/stop-bit outcome and nominal arrival time).
module tb_receiver;

  localparam int BAUD_DIV = 4;
  localparam int BIT_CLK  = 16 * BAUD_DIV;
  localparam int NOM_LAT  = 152 * BAUD_DIV + 2;
  localparam int LAT_TOL  = BAUD_DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_error;
  logic       rx_busy;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_ev;

  int cyc     = 0;
  int overlap = 0;
  int n_cmp   = 0;
  int n_bad   = 0;
  logic [7:0] last_good = 8'h00;

  receiver #(
    .BAUD_DIV (BAUD_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rx_error  (rx_error),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_status || rx_error) begin
      mon_ev.cyc  = cyc;
      mon_ev.data = rx_data;
      mon_ev.err  = rx_error;
      obs_q.push_back(mon_ev);
    end
    if (rx_status && rx_error) overlap <= overlap + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; optionally keeps the
  // stop level for 'hold' clks before returning the line high for 'gap' clks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold, input int gap);
    ev_t e;
    e.cyc = cyc;
    din = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    din = stop;
    repeat (BIT_CLK) @(negedge clk);
    if (hold > 0) begin
      repeat (hold / 2) @(negedge clk);
      check_val("hold_busy", rx_busy, 1'b0);
      repeat (hold - hold / 2) @(negedge clk);
    end
    din = 1'b1;
    repeat (gap) @(negedge clk);
    if (stop) last_good = b;
    e.data = last_good;
    e.err  = !stop;
    exp_q.push_back(e);
  endtask

  task automatic glitch(input int len, input int gap);
    din = 1'b0;
    repeat (len) @(negedge clk);
    din = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    ev_t o, e;
    int lat;
    check_val({tag, "_cnt"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      lat = o.cyc - e.cyc;
      check_val({tag, "_kind"}, o.err, e.err);
      check_val({tag, "_data"}, o.data, e.data);
      check_val({tag, "_lat"},
                ((lat >= NOM_LAT - LAT_TOL) && (lat <= NOM_LAT + LAT_TOL)) ? NOM_LAT : lat,
                NOM_LAT);
    end
    obs_q.delete();
    exp_q.delete();
    check_val({tag, "_rx_data"}, rx_data, last_good);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int gap01;
    logic [7:0] rb;
    logic       rs;
    din   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_data", rx_data, 8'h00);
    check_val("rst_status", rx_status, 1'b0);
    check_val("rst_error", rx_error, 1'b0);
    check_val("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 0, 20);
    check_events("a5");

    // Short low glitch: false start
    glitch(20, 60);
    check_val("glitch_busy", rx_busy, 1'b0);
    check_events("glitch");

    // Bad stop bit with the line held low afterwards
    send_frame(8'h3C, 1'b0, 200, 40);
    check_events("bad_stop");
    check_val("bad_stop_busy", rx_busy, 1'b0);

    // Back-to-back good frames
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 20);
    gap01 = (obs_q.size() >= 2) ? (obs_q[1].cyc - obs_q[0].cyc) : -1;
    check_val("b2b_gap", gap01, 16 * 10 * BAUD_DIV);
    check_events("b2b");

    // Reset in the middle of data bit 4
    din = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = 1'(8'h96 >> i);
      repeat (BIT_CLK) @(negedge clk);
    end
    din = 1'b1;
    repeat (20) @(negedge clk);
    check_val("pre_rst_busy", rx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_data", rx_data, 8'h00);
    check_val("mid_rst_status", rx_status, 1'b0);
    check_val("mid_rst_error", rx_error, 1'b0);
    check_val("mid_rst_busy", rx_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (200) @(negedge clk);
    check_events("rst_abort");
    send_frame(8'h5A, 1'b1, 0, 20);
    check_events("post_rst");

    // Randomized frames, bad stops and glitches
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        glitch($urandom_range(1, 24), 50);
        check_events("rnd_glitch");
      end
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, 0, rs ? $urandom_range(0, 40) : $urandom_range(4, 40));
      check_events("rnd");
    end

    repeat (100) @(negedge clk);
    check_events("final");
    check_val("status_error_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
